stochastic_adder_pipe: RTL and testbench

//  Pipelined, parametrised approximate adder for error-resilience experiments. Adds or XORs two N-bit

---
 rtl/stochastic_adder_pipe_pkg.sv | 37 +++
 rtl/stochastic_adder_pipe_lfsr.sv | 37 +++
 rtl/stochastic_adder_pipe.sv | 168 ++++++++++++++++
 tb/tb_stochastic_adder_pipe.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stochastic_adder_pipe_pkg.sv
// Shared types and constants for the stochastic adder pipeline:
// operating modes, Galois LFSR tap masks and the default seed.
package stochastic_pkg;

  typedef enum logic [1:0] {
    MODE_EXACT  = 2'd0,
    MODE_XOR    = 2'd1,
    MODE_SEXACT = 2'd2,
    MODE_SXOR   = 2'd3
  } mode_e;

  localparam logic [15:0] DEFAULT_SEED = 16'hACE1;

  // Right-shifting Galois tap masks (bit k set for polynomial term x^(k+1)).
  localparam logic [7:0]  LFSR_TAPS_8  = 8'hB8;
  localparam logic [15:0] LFSR_TAPS_16 = 16'hB400;
  localparam logic [23:0] LFSR_TAPS_24 = 24'hE10000;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h80200003;

  function automatic logic [31:0] lfsr_taps(input int unsigned w);
    case (w)
      8:       return {24'd0, LFSR_TAPS_8};
      24:      return {8'd0, LFSR_TAPS_24};
      32:      return LFSR_TAPS_32;
      default: return {16'd0, LFSR_TAPS_16};
    endcase
  endfunction

  function automatic logic is_xor(input mode_e m);
    return (m == MODE_XOR) || (m == MODE_SXOR);
  endfunction

  function automatic logic is_stochastic(input mode_e m);
    return (m == MODE_SEXACT) || (m == MODE_SXOR);
  endfunction

endpackage

// File: rtl/stochastic_adder_pipe_lfsr.sv
// Seedable right-shifting Galois LFSR; a load takes priority over a step.
module lfsr_galois #(
  parameter int           W    = 16,
  parameter logic [W-1:0] TAPS = W'(16'hB400),
  parameter logic [W-1:0] SEED = W'(16'hACE1)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         step,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] state
);

  logic [W-1:0] state_q;
  logic [W-1:0] state_d;

  always_comb begin
    state_d = state_q;
    if (load) begin
      state_d = load_val;
    end else if (step) begin
      state_d = (state_q >> 1) ^ (state_q[0] ? TAPS : '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SEED;
    end else begin
      state_q <= state_d;
    end
  end

  assign state = state_q;

endmodule

// File: rtl/stochastic_adder_pipe.sv
// Two-stage valid/ready approximate adder: exact or XOR add with optional
// LFSR-driven per-bit flips, plus a saturating count of delivered flips.
module stochastic_adder_pipe
  import stochastic_pkg::*;
#(
  parameter int                N      = 8,
  parameter int                LFSR_W = 16,
  parameter int                PROB_W = 8,
  parameter logic [LFSR_W-1:0] SEED   = LFSR_W'(DEFAULT_SEED)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      a,
  input  logic [N-1:0]      b,
  input  logic [1:0]        mode,
  input  logic [PROB_W:0]   flip_thresh,
  input  logic              seed_load,
  input  logic [LFSR_W-1:0] seed,
  input  logic              cnt_clr,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      sum,
  output logic              carry_out,
  output logic [N-1:0]      flip_mask,
  output logic [15:0]       flip_count
);

  localparam logic [LFSR_W-1:0] TAPS = LFSR_W'(lfsr_taps(LFSR_W));

  logic              s1_en, s2_en, accept, deliver;
  logic [LFSR_W-1:0] lfsr_state;
  logic [LFSR_W-1:0] seed_eff;
  logic [N-1:0]      mask_now;
  logic [N:0]        raw;
  logic [N-1:0]      eff_mask;
  logic [16:0]       pop;
  logic [16:0]       count_sum;

  logic              s1_valid_q, s1_valid_d;
  logic [N-1:0]      s1_a_q, s1_a_d, s1_b_q, s1_b_d, s1_mask_q, s1_mask_d;
  mode_e             s1_mode_q, s1_mode_d;

  logic              s2_valid_q, s2_valid_d;
  logic [N-1:0]      sum_q, sum_d, flip_mask_q, flip_mask_d;
  logic              carry_q, carry_d;
  logic [15:0]       flip_count_q, flip_count_d;

  assign s2_en    = !s2_valid_q || out_ready;
  assign s1_en    = !s1_valid_q || s2_en;
  assign in_ready = s1_en;
  assign accept   = in_valid && s1_en;
  assign deliver  = s2_valid_q && out_ready;
  assign seed_eff = (seed == '0) ? SEED : seed;

  // Stepping only on accept keeps the mask sequence independent of stalls.
  lfsr_galois #(
    .W    (LFSR_W),
    .TAPS (TAPS),
    .SEED (SEED)
  ) u_lfsr (
    .clk      (clk),
    .rst_n    (rst_n),
    .step     (accept),
    .load     (seed_load),
    .load_val (seed_eff),
    .state    (lfsr_state)
  );

  // Bit i compares the low PROB_W bits of the state rotated left by i.
  for (genvar gi = 0; gi < N; gi++) begin : g_mask
    localparam int SH = gi % LFSR_W;
    logic [LFSR_W-1:0] rot;
    logic [PROB_W-1:0] r_low;
    assign rot   = (lfsr_state << SH) | (lfsr_state >> (LFSR_W - SH));
    assign r_low = PROB_W'(rot);
    assign mask_now[gi] = is_stochastic(mode_e'(mode)) && ({1'b0, r_low} < flip_thresh);
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_a_d     = s1_a_q;
    s1_b_d     = s1_b_q;
    s1_mode_d  = s1_mode_q;
    s1_mask_d  = s1_mask_q;
    if (s1_en) begin
      s1_valid_d = in_valid;
    end
    if (accept) begin
      s1_a_d    = a;
      s1_b_d    = b;
      s1_mode_d = mode_e'(mode);
      s1_mask_d = mask_now;
    end
  end

  always_comb begin
    if (is_xor(s1_mode_q)) begin
      raw = {1'b0, s1_a_q ^ s1_b_q};
    end else begin
      raw = {1'b0, s1_a_q} + {1'b0, s1_b_q};
    end
    eff_mask = is_stochastic(s1_mode_q) ? s1_mask_q : '0;
  end

  always_comb begin
    s2_valid_d  = s2_valid_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    flip_mask_d = flip_mask_q;
    if (s2_en) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        sum_d       = raw[N-1:0] ^ eff_mask;
        carry_d     = raw[N] && !is_xor(s1_mode_q);
        flip_mask_d = eff_mask;
      end
    end
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) begin
      pop = pop + 17'(flip_mask_q[i]);
    end
    count_sum    = {1'b0, flip_count_q} + pop;
    flip_count_d = flip_count_q;
    if (cnt_clr) begin
      flip_count_d = '0;
    end else if (deliver) begin
      flip_count_d = count_sum[16] ? 16'hFFFF : count_sum[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q   <= 1'b0;
      s1_a_q       <= '0;
      s1_b_q       <= '0;
      s1_mode_q    <= MODE_EXACT;
      s1_mask_q    <= '0;
      s2_valid_q   <= 1'b0;
      sum_q        <= '0;
      carry_q      <= 1'b0;
      flip_mask_q  <= '0;
      flip_count_q <= '0;
    end else begin
      s1_valid_q   <= s1_valid_d;
      s1_a_q       <= s1_a_d;
      s1_b_q       <= s1_b_d;
      s1_mode_q    <= s1_mode_d;
      s1_mask_q    <= s1_mask_d;
      s2_valid_q   <= s2_valid_d;
      sum_q        <= sum_d;
      carry_q      <= carry_d;
      flip_mask_q  <= flip_mask_d;
      flip_count_q <= flip_count_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign sum        = sum_q;
  assign carry_out  = carry_q;
  assign flip_mask  = flip_mask_q;
  assign flip_count = flip_count_q;

endmodule

// File: tb/tb_stochastic_adder_pipe.sv
// Randomised bench for stochastic_adder_pipe with a transaction-level
// reference model (integer LFSR, expected-result queue, flip counter).
module tb_stochastic_adder_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid, in_ready, seed_load, cnt_clr, out_valid, out_ready, carry_out;
  logic [7:0]  a, b, sum, flip_mask;
  logic [1:0]  mode;
  logic [8:0]  flip_thresh;
  logic [15:0] seed, flip_count;

  always #5 clk = ~clk;

  stochastic_adder_pipe dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .mode        (mode),
    .flip_thresh (flip_thresh),
    .seed_load   (seed_load),
    .seed        (seed),
    .cnt_clr     (cnt_clr),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .sum         (sum),
    .carry_out   (carry_out),
    .flip_mask   (flip_mask),
    .flip_count  (flip_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [7:0] sum;
    logic       carry;
    logic [7:0] mask;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        e;
  int unsigned m_lfsr = 16'hACE1;
  int unsigned m_count = 0;
  int unsigned raw;
  int          delivered = 0;
  logic        recording = 1'b0;
  logic        rand_ready = 1'b0;
  logic [7:0]  rec_q[$];

  function automatic int unsigned lfsr_next(input int unsigned s);
    return (s & 1) ? ((s >> 1) ^ 32'hB400) : (s >> 1);
  endfunction

  function automatic logic [7:0] ref_mask(input int unsigned s, input int unsigned thr, input logic [1:0] md);
    logic [7:0]  m;
    int unsigned rot;
    m = 8'h00;
    if (md < 2) return m;
    for (int i = 0; i < 8; i++) begin
      rot = ((s << i) | (s >> (16 - i))) & 32'hFFFF;
      if ((rot % 256) < thr) m[i] = 1'b1;
    end
    return m;
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      m_lfsr  = 16'hACE1;
      m_count = 0;
    end else begin
      check("flip_count", flip_count, m_count);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("out_without_expect", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e.sum);
          check("carry_out", carry_out, e.carry);
          check("flip_mask", flip_mask, e.mask);
          $display("deliver #%0d sum=%02h carry=%0b mask=%02h", delivered, sum, carry_out, flip_mask);
          m_count = m_count + $countones(e.mask);
          if (m_count > 16'hFFFF) m_count = 16'hFFFF;
          delivered++;
          if (recording) rec_q.push_back(sum);
        end
      end
      if (cnt_clr) m_count = 0;
      if (in_valid && in_ready) begin
        raw     = mode[0] ? int'(a ^ b) : int'(a) + int'(b);
        e.mask  = ref_mask(m_lfsr, flip_thresh, mode);
        e.sum   = 8'(raw) ^ e.mask;
        e.carry = mode[0] ? 1'b0 : raw[8];
        exp_q.push_back(e);
      end
      if (seed_load) m_lfsr = (seed == 0) ? 16'hACE1 : seed;
      else if (in_valid && in_ready) m_lfsr = lfsr_next(m_lfsr);
    end
  end

  always @(posedge clk) begin
    if (rand_ready) begin
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // ---------------- driver helpers ----------------
  task automatic wait_accept();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_wait", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] ta, input logic [7:0] tbv, input logic [1:0] tm, input logic [8:0] tt);
    a = ta; b = tbv; mode = tm; flip_thresh = tt; in_valid = 1'b1;
    wait_accept();
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while ((exp_q.size() != 0 || out_valid) && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_left", exp_q.size(), 0);
  endtask

  task automatic load_seed(input logic [15:0] s);
    seed = s; seed_load = 1'b1;
    @(posedge clk);
    #1;
    seed_load = 1'b0;
  endtask

  logic [7:0] ra[10], rb[10], first[10];
  int         base;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    in_valid = 0; a = 0; b = 0; mode = 0; flip_thresh = 0;
    seed_load = 0; seed = 0; cnt_clr = 0; out_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_carry", carry_out, 0);
    check("rst_mask", flip_mask, 0);
    check("rst_count", flip_count, 0);
    rst_n = 1'b1;

    // exact add with carry, two-cycle latency
    send(8'd200, 8'd100, 2'd0, 9'd0);
    check("t1_not_yet", out_valid, 0);
    @(posedge clk); #1;
    check("t1_valid", out_valid, 1);
    check("t1_sum", sum, 8'd44);
    check("t1_carry", carry_out, 1);
    check("t1_mask", flip_mask, 0);
    drain();

    // XOR add, then stochastic exact with zero threshold
    send(8'hF0, 8'h3C, 2'd1, 9'd0);
    @(posedge clk); #1;
    check("t2_sum", sum, 8'hCC);
    check("t2_carry", carry_out, 0);
    for (int i = 0; i < 100; i++) send(8'($urandom), 8'($urandom), 2'd2, 9'd0);
    drain();

    // fully random beats under random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      send(8'($urandom), 8'($urandom), 2'($urandom), 9'($urandom_range(0, 300)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_ready = 1'b0;
    @(posedge clk); #1;
    drain();

    // certain flips and counter increment
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("t3_cleared", flip_count, 0);
    send(8'hAA, 8'h00, 2'd3, 9'd256);
    @(posedge clk); #1;
    check("t3_sum", sum, 8'h55);
    check("t3_mask", flip_mask, 8'hFF);
    @(posedge clk); #1;
    check("t3_count", flip_count, 8);
    drain();

    // backpressure: third beat held off, outputs stable
    out_ready = 1'b0;
    base = delivered;
    send(8'd1, 8'd2, 2'd0, 9'd0);
    send(8'd3, 8'd4, 2'd0, 9'd0);
    a = 8'd5; b = 8'd6; mode = 2'd0; in_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t4_in_ready", in_ready, 0);
      check("t4_hold_valid", out_valid, 1);
      check("t4_hold_sum", sum, 8'd3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    wait_accept();
    drain();
    check("t4_delivered", delivered - base, 3);

    // seeded replay reproducibility
    for (int i = 0; i < 10; i++) begin
      ra[i] = 8'($urandom); rb[i] = 8'($urandom);
    end
    load_seed(16'h1234);
    rec_q.delete();
    recording = 1'b1;
    for (int i = 0; i < 10; i++) send(ra[i], rb[i], 2'd3, 9'd128);
    drain();
    for (int i = 0; i < 10; i++) first[i] = (rec_q.size() > i) ? rec_q[i] : 8'h00;
    rec_q.delete();
    load_seed(16'h1234);
    for (int i = 0; i < 10; i++) send(ra[i], rb[i], 2'd3, 9'd128);
    drain();
    recording = 1'b0;
    check("t5_replay_len", rec_q.size(), 10);
    for (int i = 0; i < 10 && i < rec_q.size(); i++) check("t5_replay", rec_q[i], first[i]);
    load_seed(16'h0000);
    send(8'h5A, 8'h33, 2'd3, 9'd128);
    @(posedge clk); #1;
    check("t5_seed0_mask", flip_mask, ref_mask(16'hACE1, 128, 2'd3));
    drain();

    // asynchronous reset with both stages full
    out_ready = 1'b0;
    send(8'd10, 8'd20, 2'd3, 9'd128);
    send(8'd30, 8'd40, 2'd3, 9'd128);
    #1;
    rst_n = 1'b0;
    #1;
    check("t6_rst_valid", out_valid, 0);
    check("t6_rst_count", flip_count, 0);
    check("t6_rst_sum", sum, 0);
    check("t6_rst_ready", in_ready, 1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    send(8'h11, 8'h22, 2'd3, 9'd128);
    @(posedge clk); #1;
    check("t6_seed_mask", flip_mask, ref_mask(16'hACE1, 128, 2'd3));
    drain();

    // clear coinciding with a delivery of eight flips
    send(8'hFF, 8'h01, 2'd3, 9'd256);
    @(posedge clk); #1;
    check("t6_clr_valid", out_valid, 1);
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
    check("t6_clr_count", flip_count, 0);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
